// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational alu between two requesters,
// each with its own request and response handshake.
module alu_arbiter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             r0_req_valid,
   output logic             r0_req_ready,
   input  logic [WIDTH-1:0] r0_op1,
   input  logic [WIDTH-1:0] r0_op2,
   input  logic             r0_is_add,
   input  logic             r0_is_addi,
   output logic             r0_rsp_valid,
   input  logic             r0_rsp_ready,
   output logic [WIDTH-1:0] r0_rsp_result,
   input  logic             r1_req_valid,
   output logic             r1_req_ready,
   input  logic [WIDTH-1:0] r1_op1,
   input  logic [WIDTH-1:0] r1_op2,
   input  logic             r1_is_add,
   input  logic             r1_is_addi,
   output logic             r1_rsp_valid,
   input  logic             r1_rsp_ready,
   output logic [WIDTH-1:0] r1_rsp_result,
   output logic [WIDTH-1:0] alu_op1,
   output logic [WIDTH-1:0] alu_op2,
   output logic             alu_is_add,
   output logic             alu_is_addi,
   output logic             alu_reset,
   input  logic [WIDTH-1:0] alu_result,
   output logic             busy,
   output logic             owner
);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] op1_q, op2_q, result_q;
   logic             is_add_q, is_addi_q;
   logic             owner_q, last_grant_q;
   logic             grant_any, grant_sel, rsp_hs, in_txn;

   // Reset is folded into the grant so every output reads 0 while reset is held.
   assign grant_any = reset && (state_q == IDLE) && (r0_req_valid || r1_req_valid);
   assign grant_sel = (r0_req_valid && r1_req_valid) ? ~last_grant_q : r1_req_valid;
   assign rsp_hs    = (state_q == RESP) && (owner_q ? r1_rsp_ready : r0_rsp_ready);

   // NOTE: state_d gets its default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (grant_any) state_d = EXEC;
         EXEC:    state_d = RESP;
         RESP:    if (rsp_hs) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: every flop, datapath registers included, is cleared by reset so an
   // aborted transaction leaves nothing behind.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         op1_q        <= '0;
         op2_q        <= '0;
         is_add_q     <= 1'b0;
         is_addi_q    <= 1'b0;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         result_q     <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q <= state_d;
         if (grant_any) begin
            owner_q   <= grant_sel;
            op1_q     <= grant_sel ? r1_op1     : r0_op1;
            op2_q     <= grant_sel ? r1_op2     : r0_op2;
            is_add_q  <= grant_sel ? r1_is_add  : r0_is_add;
            is_addi_q <= grant_sel ? r1_is_addi : r0_is_addi;
         end
         if (state_q == EXEC) result_q <= alu_result;
         if (rsp_hs) last_grant_q <= owner_q;
      end
   end

   assign in_txn = (state_q != IDLE);

   assign r0_req_ready = grant_any && !grant_sel;
   assign r1_req_ready = grant_any &&  grant_sel;

   assign r0_rsp_valid  = (state_q == RESP) && !owner_q;
   assign r1_rsp_valid  = (state_q == RESP) &&  owner_q;
   assign r0_rsp_result = r0_rsp_valid ? result_q : '0;
   assign r1_rsp_result = r1_rsp_valid ? result_q : '0;

   // Operands stay on the alu through RESP; IDLE presents an all-zero operation.
   assign alu_op1     = in_txn ? op1_q : '0;
   assign alu_op2     = in_txn ? op2_q : '0;
   assign alu_is_add  = in_txn && is_add_q;
   assign alu_is_addi = in_txn && is_addi_q;
   assign alu_reset   = ~reset;

   assign busy  = in_txn;
   assign owner = owner_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized traffic,
// checked cycle by cycle against a transaction-level reference model.
module tb_alu_arbiter;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset;
   logic         r0_req_valid, r0_req_ready, r0_is_add, r0_is_addi, r0_rsp_valid, r0_rsp_ready;
   logic [W-1:0] r0_op1, r0_op2, r0_rsp_result;
   logic         r1_req_valid, r1_req_ready, r1_is_add, r1_is_addi, r1_rsp_valid, r1_rsp_ready;
   logic [W-1:0] r1_op1, r1_op2, r1_rsp_result;
   logic [W-1:0] alu_op1, alu_op2, alu_result;
   logic         alu_is_add, alu_is_addi, alu_reset, busy, owner;

   always #5 clk = ~clk;

   alu_arbiter #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset),
      .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready), .r0_op1(r0_op1), .r0_op2(r0_op2),
      .r0_is_add(r0_is_add), .r0_is_addi(r0_is_addi), .r0_rsp_valid(r0_rsp_valid),
      .r0_rsp_ready(r0_rsp_ready), .r0_rsp_result(r0_rsp_result),
      .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready), .r1_op1(r1_op1), .r1_op2(r1_op2),
      .r1_is_add(r1_is_add), .r1_is_addi(r1_is_addi), .r1_rsp_valid(r1_rsp_valid),
      .r1_rsp_ready(r1_rsp_ready), .r1_rsp_result(r1_rsp_result),
      .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_is_add(alu_is_add), .alu_is_addi(alu_is_addi),
      .alu_reset(alu_reset), .alu_result(alu_result), .busy(busy), .owner(owner)
   );

   // Stand-in alu: add for either flag, xor when neither is set (makes flag loss visible).
   assign alu_result = (alu_is_add || alu_is_addi) ? alu_op1 + alu_op2 : alu_op1 ^ alu_op2;

   typedef struct packed {
      logic [W-1:0] op1;
      logic [W-1:0] op2;
      logic         add;
      logic         addi;
   } req_t;

   req_t         q0[$], q1[$];
   int           served_owner[$];
   logic [W-1:0] served_res[$];

   int           n_tests = 0, n_fail = 0;
   bit           rand_mode = 0;

   // Reference model: one transaction in flight, its age in cycles since acceptance.
   bit           m_busy = 0, m_owner = 0, m_last = 1;
   int           m_age = 0, m_grant = -1;
   req_t         m_txn;
   logic [W-1:0] obs_res;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] ref_alu(input req_t r);
      return (r.add || r.addi) ? r.op1 + r.op2 : r.op1 ^ r.op2;
   endfunction

   function automatic req_t mk(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic add, input logic addi);
      req_t r;
      r.op1 = a; r.op2 = b; r.add = add; r.addi = addi;
      return r;
   endfunction

   function automatic req_t rand_req();
      req_t r;
      r.op1  = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : W'($urandom);
      r.op2  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 2)) : W'($urandom);
      r.add  = 1'($urandom);
      r.addi = 1'($urandom);
      return r;
   endfunction

   task automatic drive();
      bit d0, d1;
      d0 = rand_mode && ($urandom_range(0, 7) == 0);
      d1 = rand_mode && ($urandom_range(0, 7) == 0);
      if (rand_mode && q0.size() > 0 && $urandom_range(0, 9) == 0) q0[0].op1 = W'($urandom);
      if (rand_mode && q1.size() > 0 && $urandom_range(0, 9) == 0) q1[0].op2 = W'($urandom);
      r0_req_valid = (q0.size() > 0) && !d0;
      r1_req_valid = (q1.size() > 0) && !d1;
      if (q0.size() > 0) {r0_op1, r0_op2, r0_is_add, r0_is_addi} = q0[0];
      else               {r0_op1, r0_op2, r0_is_add, r0_is_addi} = rand_req();
      if (q1.size() > 0) {r1_op1, r1_op2, r1_is_add, r1_is_addi} = q1[0];
      else               {r1_op1, r1_op2, r1_is_add, r1_is_addi} = rand_req();
   endtask

   task automatic compare();
      if (!reset) begin
         m_grant = -1;
         check("rst_req_ready0", r0_req_ready, 0);
         check("rst_req_ready1", r1_req_ready, 0);
         check("rst_rsp_valid0", r0_rsp_valid, 0);
         check("rst_rsp_valid1", r1_rsp_valid, 0);
         check("rst_rsp_result0", r0_rsp_result, 0);
         check("rst_rsp_result1", r1_rsp_result, 0);
         check("rst_alu_op1", alu_op1, 0);
         check("rst_alu_op2", alu_op2, 0);
         check("rst_alu_flags", {alu_is_add, alu_is_addi}, 0);
         check("rst_alu_reset", alu_reset, 1);
         check("rst_busy", busy, 0);
         check("rst_owner", owner, 0);
         return;
      end
      check("alu_reset", alu_reset, 0);
      if (!m_busy) begin
         if (r0_req_valid && r1_req_valid) m_grant = m_last ? 0 : 1;
         else if (r0_req_valid)            m_grant = 0;
         else if (r1_req_valid)            m_grant = 1;
         else                              m_grant = -1;
         check("idle_req_ready0", r0_req_ready, m_grant == 0);
         check("idle_req_ready1", r1_req_ready, m_grant == 1);
         check("idle_busy", busy, 0);
         check("idle_rsp_valid", {r0_rsp_valid, r1_rsp_valid}, 0);
         check("idle_alu", {alu_op1, alu_op2, alu_is_add, alu_is_addi}, 0);
      end else begin
         m_grant = -1;
         check("busy_req_ready", {r0_req_ready, r1_req_ready}, 0);
         check("busy", busy, 1);
         check("owner", owner, m_owner);
         check("alu_op1", alu_op1, m_txn.op1);
         check("alu_op2", alu_op2, m_txn.op2);
         check("alu_flags", {alu_is_add, alu_is_addi}, {m_txn.add, m_txn.addi});
         check("rsp_valid0", r0_rsp_valid, m_age >= 2 && !m_owner);
         check("rsp_valid1", r1_rsp_valid, m_age >= 2 && m_owner);
         if (m_age >= 2) begin
            obs_res = m_owner ? r1_rsp_result : r0_rsp_result;
            check("rsp_result", obs_res, ref_alu(m_txn));
         end
      end
   endtask

   task automatic update();
      if (!reset) begin
         m_busy = 0; m_last = 1; m_age = 0;
      end else if (!m_busy) begin
         if (m_grant >= 0) begin
            m_busy  = 1;
            m_owner = (m_grant == 1);
            m_age   = 1;
            if (m_owner) m_txn = q1.pop_front();
            else         m_txn = q0.pop_front();
         end
      end else if (m_age < 2) begin
         m_age = 2;
      end else if (m_owner ? r1_rsp_ready : r0_rsp_ready) begin
         served_owner.push_back(int'(m_owner));
         served_res.push_back(obs_res);
         m_busy = 0;
         m_last = m_owner;
      end
   endtask

   // NOTE: inputs change with blocking assignments 1 time unit after the edge; outputs are sampled at negedge.
   task automatic cycle(input int n = 1);
      for (int i = 0; i < n; i++) begin
         drive();
         @(negedge clk);
         compare();
         @(posedge clk);
         update();
         #1;
      end
   endtask

   initial begin
      int base;
      reset = 1'b0;
      r0_rsp_ready = 1'b1;
      r1_rsp_ready = 1'b1;
      drive();
      @(posedge clk); #1;

      // Reset held for two cycles, then released.
      cycle(2);
      reset = 1'b1;
      cycle(1);

      // Single requester: add(2,1).
      q0.push_back(mk(2, 1, 1, 0));
      cycle(3);
      check("t2_count", served_owner.size(), 1);
      if (served_owner.size() == 1) begin
         check("t2_owner", served_owner[0], 0);
         check("t2_result", served_res[0], 3);
      end

      // Tie from reset: r0 first, then r1, then r0 again.
      reset = 1'b0;
      cycle(1);
      reset = 1'b1;
      base = served_owner.size();
      q0.push_back(mk(1, 2, 0, 1));
      q0.push_back(mk(10, 20, 1, 0));
      q1.push_back(mk(5, 7, 1, 0));
      cycle(9);
      check("t3_count", served_owner.size(), base + 3);
      if (served_owner.size() == base + 3) begin
         check("t3_owner_a", served_owner[base], 0);
         check("t3_result_a", served_res[base], 3);
         check("t3_owner_b", served_owner[base+1], 1);
         check("t3_result_b", served_res[base+1], 12);
         check("t3_owner_c", served_owner[base+2], 0);
         check("t3_result_c", served_res[base+2], 30);
      end

      // Wrap-around with a four-cycle response stall while r1 waits.
      base = served_owner.size();
      r0_rsp_ready = 1'b0;
      q0.push_back(mk(32'hFFFF_FFFF, 1, 1, 0));
      cycle(1);
      q1.push_back(mk(40, 2, 0, 1));
      cycle(5);
      check("t4_stall_valid", r0_rsp_valid, 1);
      check("t4_stall_result", r0_rsp_result, 0);
      r0_rsp_ready = 1'b1;
      cycle(4);
      check("t4_count", served_owner.size(), base + 2);
      if (served_owner.size() == base + 2) begin
         check("t4_wrap_result", served_res[base], 0);
         check("t4_r1_result", served_res[base+1], 42);
      end

      // Reset during r1's EXEC: dropped, then the next tie goes to r0.
      base = served_owner.size();
      q1.push_back(mk(3, 4, 1, 0));
      cycle(1);
      reset = 1'b0;
      cycle(1);
      reset = 1'b1;
      check("t5_no_rsp", served_owner.size(), base);
      q0.push_back(mk(6, 1, 1, 0));
      q1.push_back(mk(8, 1, 0, 1));
      cycle(6);
      check("t5_count", served_owner.size(), base + 2);
      if (served_owner.size() == base + 2) begin
         check("t5_tie_owner", served_owner[base], 0);
         check("t5_tie_result", served_res[base], 7);
         check("t5_second_result", served_res[base+1], 9);
      end

      // Back-to-back: four requests complete in twelve cycles, alternating.
      base = served_owner.size();
      q0.push_back(mk(100, 1, 1, 0));
      q0.push_back(mk(100, 2, 1, 0));
      q1.push_back(mk(200, 1, 0, 1));
      q1.push_back(mk(200, 2, 0, 1));
      cycle(12);
      check("t6_count", served_owner.size(), base + 4);
      if (served_owner.size() == base + 4) begin
         check("t6_first", served_owner[base], 0);
         for (int i = 1; i < 4; i++)
            check("t6_alternate", served_owner[base+i], 1 - served_owner[base+i-1]);
      end

      // Randomized traffic with stalls, withdrawn requests and occasional reset pulses.
      rand_mode = 1;
      for (int i = 0; i < 3000; i++) begin
         if (q0.size() < 2 && $urandom_range(0, 2) == 0) q0.push_back(rand_req());
         if (q1.size() < 2 && $urandom_range(0, 2) == 0) q1.push_back(rand_req());
         r0_rsp_ready = ($urandom_range(0, 3) != 0);
         r1_rsp_ready = ($urandom_range(0, 3) != 0);
         reset        = ($urandom_range(0, 299) != 0);
         cycle(1);
      end
      rand_mode = 0;
      reset = 1'b1;
      r0_rsp_ready = 1'b1;
      r1_rsp_ready = 1'b1;
      cycle(20);
      check("drain_q0", q0.size(), 0);
      check("drain_q1", q1.size(), 0);
      check("drain_busy", busy, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
